dma_mem_responder: RTL
======================

Name: dma_mem_responder

Overview:
- Synthesizable DMA memory responder: the target end of the nn DMA interface.
- Accepts nn read requests (rd_en/rd_addr) and returns data after a fixed pipeline latency, with an explicit valid strobe. Accepts nn write requests (wr_en/wr_addr/wr_data).
- Periodically enters a refresh window. During refresh it deasserts ready and drops incoming requests.
- Sits between nn and the shared on-chip buffer. Replaces the combinational memory stub used in bring-up.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 10, address width; memory depth is 2**ADDR_W words.
- RD_LAT, 2, read latency in cycles (legal range 1..4).
- REFRESH_PERIOD, 64, cycles spent in SERVE between refresh windows (legal minimum 2).
- REFRESH_CYC, 4, length of a refresh window in cycles (legal minimum 1).

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  reset; synchronous, active-low.
- i_dma_rd_en  in  1  read request.
- i_dma_rd_addr  in  ADDR_W  read address.
- o_dma_rd_ready  out  1  high means requests are accepted this cycle.
- o_dma_rd_data  out  DATA_W  read data; equals 0 whenever o_dma_rd_valid is low.
- o_dma_rd_valid  out  1  read data valid strobe.
- i_dma_wr_en  in  1  write request.
- i_dma_wr_addr  in  ADDR_W  write address.
- i_dma_wr_data  in  DATA_W  write data.
- o_drop_cnt  out  8  number of cycles in which a request was dropped; saturates at 255.

Behaviour:
- Reset (i_rst low at a rising edge):
  - o_dma_rd_ready=0, o_dma_rd_valid=0, o_dma_rd_data=0, o_drop_cnt=0.
  - Read pipeline valid bits cleared; refresh counter=0; state=SERVE.
  - Memory contents are not cleared.
- Reset mid-operation: in-flight reads are discarded and no valid strobe appears for them.
- First edge with i_rst high: o_dma_rd_ready goes 1.
- States:
  - SERVE: o_dma_rd_ready=1. The counter increments each cycle. When it reaches REFRESH_PERIOD-1, the next state is REFRESH and the counter clears.
  - REFRESH: o_dma_rd_ready=0 for exactly REFRESH_CYC cycles, then return to SERVE with the counter at 0.
- o_dma_rd_ready is registered and reflects the current state.
- Acceptance: a request is sampled at edge t only if o_dma_rd_ready=1 during the cycle before edge t.
- Read timing: a read accepted at edge t produces o_dma_rd_valid=1 and o_dma_rd_data=mem[addr] in the cycle following edge t+RD_LAT-1.
  - With RD_LAT=2: request in cycle c, data in cycle c+2.
  - Reads are fully pipelined: one per cycle, returned in order, no bubbles.
- Write: when accepted, mem[wr_addr] is updated at edge t.
- Simultaneous accepted read and write to the same address are write-first: the read returns the new data. Different addresses proceed independently.
- Reads already in the pipeline when REFRESH begins complete normally and on schedule.
- Drop rule: in any cycle with ready=0 and (rd_en or wr_en), the request is ignored and memory is untouched.
  - o_drop_cnt increments by 1 per such cycle, including a cycle where both rd_en and wr_en are high.
  - o_drop_cnt saturates at 255.
- Address width: addresses are used in full with no wrap; the nn 5/6-bit addresses are zero-extended by the integrator.

Test Plan:
- Reset then hold: i_rst low for 2 edges, then high -> ready 0 during reset, 1 from the first edge after release; valid stays 0 and o_drop_cnt=0.
- Write/read back: write 16'h0101 to addr 5 and 16'hBEEF to addr 6, then read 5,6,5 back-to-back -> with RD_LAT=2, valid high for 3 consecutive cycles starting 2 cycles after the first read, data 0101, BEEF, 0101.
- Write-first collision: same cycle wr addr 9 = 16'h1234 and rd addr 9 -> 2 cycles later data=16'h1234.
- Refresh window: after release, count 64 ready-high cycles -> ready low for exactly 4 cycles, then high. A read issued in the last SERVE cycle still returns valid. Reads issued while ready is low produce no valid, and o_drop_cnt increments per cycle (4 after a fully requested window).
- Dropped write: issue wr addr 3 = 16'hAAAA during REFRESH, then read addr 3 in SERVE -> returns the previous value (16'h0000 if preloaded to 0); o_drop_cnt +1.
- Reset mid-read: reads in flight when i_rst is asserted -> no valid strobe appears; after release the pipeline is empty and data=0.

Source files
------------

// File: rtl/dma_mem_responder.sv
// ---------------------------------------------------------------------------
// dma_mem_responder
//
// Target end of the nn DMA interface, sitting in front of the shared on-chip
// buffer. Reads return after a fixed RD_LAT-cycle pipeline with a valid
// strobe; writes land in memory at the accepting edge. The block periodically
// enters a refresh window during which ready is low and any request is
// dropped (and counted).
//
// Handshake: a request (rd_en and/or wr_en) is accepted at a rising edge only
// if o_dma_rd_ready was high during the cycle leading up to that edge; there
// is no back-pressure beyond that, so a request seen while ready is low is
// simply lost and o_drop_cnt records the cycle.
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst           synchronous active-low reset
//   i_dma_rd_en     read request
//   i_dma_rd_addr   read address (ADDR_W)
//   o_dma_rd_ready  registered: high while serving requests
//   o_dma_rd_data   read data (DATA_W), zero whenever valid is low
//   o_dma_rd_valid  read data valid strobe
//   i_dma_wr_en     write request
//   i_dma_wr_addr   write address (ADDR_W)
//   i_dma_wr_data   write data (DATA_W)
//   o_drop_cnt      cycles in which a request was dropped, saturating at 255
// ---------------------------------------------------------------------------
module dma_mem_responder #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 10,
    parameter int RD_LAT         = 2,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_CYC    = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_dma_rd_en,
    input  logic [ADDR_W-1:0] i_dma_rd_addr,
    output logic              o_dma_rd_ready,
    output logic [DATA_W-1:0] o_dma_rd_data,
    output logic              o_dma_rd_valid,
    input  logic              i_dma_wr_en,
    input  logic [ADDR_W-1:0] i_dma_wr_addr,
    input  logic [DATA_W-1:0] i_dma_wr_data,
    output logic [7:0]        o_drop_cnt
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int CNT_MAX = (REFRESH_PERIOD > REFRESH_CYC) ? REFRESH_PERIOD : REFRESH_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(REFRESH_PERIOD - 1);
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYC - 1);

    typedef enum logic [0:0] {
        ST_SERVE   = 1'b0,
        ST_REFRESH = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ready;
    logic [7:0]         r_drop_cnt;

    logic [DATA_W-1:0]  r_mem [0:DEPTH-1];
    logic [RD_LAT-1:0]  r_vld;
    logic [DATA_W-1:0]  r_dat [0:RD_LAT-1];

    logic               w_rd_acc;
    logic               w_wr_acc;
    logic               w_drop;
    logic [DATA_W-1:0]  w_rd_word;
    logic [DATA_W-1:0]  w_rd_fwd;

    // Memory writes are gated by i_rst so a request that happens to coincide
    // with a reset edge cannot corrupt the buffer.
    assign w_rd_acc  = r_ready & i_dma_rd_en;
    assign w_wr_acc  = i_rst & r_ready & i_dma_wr_en;
    assign w_drop    = ~r_ready & (i_dma_rd_en | i_dma_wr_en);
    assign w_rd_word = r_mem[i_dma_rd_addr];

    // Write-first: a read accepted on the same edge as a write to the same
    // address must return the new data, so forward it around the array.
    assign w_rd_fwd  = (w_wr_acc && (i_dma_wr_addr == i_dma_rd_addr)) ? i_dma_wr_data : w_rd_word;

    // Memory array: intentionally not reset, contents survive i_rst.
    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[i_dma_wr_addr] <= i_dma_wr_data;
        end
    end

    // Serve/refresh FSM with registered ready. After reset the state is SERVE
    // but ready is still low; the first released edge only raises ready, so
    // the counter measures exactly REFRESH_PERIOD ready-high cycles.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= ST_SERVE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_SERVE: begin
                    if (!r_ready) begin
                        r_ready <= 1'b1;
                    end else if (r_cnt == PERIOD_LAST) begin
                        r_state <= ST_REFRESH;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_REFRESH: begin
                    if (r_cnt == REFRESH_LAST) begin
                        r_state <= ST_SERVE;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_SERVE;
                    r_cnt   <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Read pipeline. Data stages carry zero alongside a cleared valid bit so
    // the output stage needs no extra masking. Refresh does not touch it, so
    // reads already in flight finish on schedule.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_rd_acc;
            r_dat[0] <= w_rd_acc ? w_rd_fwd : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    // One increment per dropping cycle, even if both rd_en and wr_en are high.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign o_dma_rd_ready = r_ready;
    assign o_dma_rd_valid = r_vld[RD_LAT-1];
    assign o_dma_rd_data  = r_dat[RD_LAT-1];
    assign o_drop_cnt     = r_drop_cnt;

endmodule
